lfsr_bist_ctrl: RTL and testbench
=================================

// Module: lfsr_bist_ctrl
// PURPOSE
//   Built-in self-test sequencer around a Fibonacci LFSR pattern generator.
//   On start: seeds the LFSR, streams NUM_PAT patterns to the unit under test,
//   and compacts the UUT responses into a MISR. Compares the final signature
//   against GOLDEN and reports pass/fail.
//   Sits between the test-mode top level and the combinational UUT.
// PARAMETERS
//   WIDTH   3       LFSR/MISR/pattern width in bits (>=2)
//   TAPS    3'b110  feedback mask, bit i-1 = stage i; feedback = ^(reg & TAPS)
//   SEED    3'b100  LFSR load value; must be nonzero (0 is replaced by 1)
//   NUM_PAT 7       patterns per run (>=1)
//   GOLDEN  3'b110  expected MISR signature
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, synchronous, active-high
//   start      in   1      level-sampled run request; honoured only in IDLE
//   pat_out    out  WIDTH  current pattern to UUT (LFSR register)
//   pat_valid  out  1      pat_out is a counted test pattern (state RUN)
//   resp_in    in   WIDTH  UUT response to pat_out, same cycle
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse, run complete
//   pass       out  1      signature == GOLDEN; held until next accepted start
//   signature  out  WIDTH  MISR register
// BEHAVIOUR
//   Reset: state=IDLE, LFSR=SEED, MISR=0, counter=0, pass=0, done=0,
//     pat_valid=0, busy=0. Reset overrides everything, mid-run included.
//   Shift rule, both registers: {r[WIDTH-2:0], ^(r & TAPS)}. MISR also XORs
//     in resp_in after the shift.
//   FSM: IDLE -start-> LOAD -> RUN (NUM_PAT cycles) -> CHECK -> DONE -> IDLE.
//   IDLE: LFSR/MISR hold; start=1 at edge k -> LOAD; pass cleared at edge k.
//   LOAD: LFSR<=SEED, MISR<=0, counter<=0.
//   RUN: pat_valid=1. Each edge: MISR absorbs resp_in, LFSR advances,
//     counter++. After the NUM_PAT-th absorb -> CHECK.
//     The first RUN cycle shows SEED.
//   CHECK: pass <= (MISR == GOLDEN).
//   DONE: done=1 for exactly one cycle; then IDLE.
//   Latency: done high in the cycle after edge k+NUM_PAT+2 (k = start edge).
//   start while busy: ignored, no queueing. start held high: new run
//     begins at the edge leaving DONE->IDLE+1, i.e. rerun after one IDLE cycle.
//   Counter width clog2(NUM_PAT+1); no wrap inside a run.
//   LFSR/MISR hold in IDLE, so pat_out/signature remain readable after a run.
// CONFIGURATION
//   BIST_ABORT_EN defined: adds input abort (1 bit).
//     abort=1 in any non-IDLE state -> IDLE at the next edge,
//     with pass=0 and no done pulse. abort has priority over the FSM,
//     but rst has priority over abort. abort in IDLE: no effect.
//   BIST_ABORT_EN undefined: no abort port; a run always completes.
// TESTING
//   1 Reset, then idle: busy=0, done=0, pass=0, pat_out=3'b100, signature=0.
//   2 Loopback resp_in=pat_out, start 1 cycle: pat_out in RUN =
//     100,001,010,101,011,111,110; signature=110; done 9 cycles after
//     start edge; pass=1.
//   3 As 2 but flip bit0 of 7th response (110->111): signature=111, pass=0.
//   4 Pulse start during RUN and CHECK: no restart; single done pulse.
//     Hold start high: second run starts after 1 IDLE cycle; pass clears at
//     its start edge.
//   5 Assert rst on 4th RUN cycle: next cycle IDLE, all outputs at reset
//     values; new start gives the same results as 2.
//   6 (BIST_ABORT_EN) abort on 3rd RUN cycle: IDLE next cycle, no done pulse,
//     pass=0, busy=0.

Source files
------------

// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer: seeds a Fibonacci LFSR, streams NUM_PAT patterns, compacts responses in a MISR.
// Optional `define BIST_ABORT_EN adds an abort input that returns the sequencer to IDLE.
module lfsr_bist_ctrl #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] TAPS    = 3'b110,
  parameter logic [WIDTH-1:0] SEED    = 3'b100,
  parameter int               NUM_PAT = 7,
  parameter logic [WIDTH-1:0] GOLDEN  = 3'b110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] pat_out,
  output logic             pat_valid,
  input  logic [WIDTH-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
`ifdef BIST_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int               CW     = $clog2(NUM_PAT + 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_V = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CW-1:0]    LAST   = CW'(NUM_PAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] misr;
  logic [CW-1:0]    cnt;
  logic             abort_req;

`ifdef BIST_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] r);
    return {r[WIDTH-2:0], ^(r & TAPS)};
  endfunction

  assign pat_out   = lfsr;
  assign signature = misr;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED_V;
      misr      <= '0;
      cnt       <= '0;
      pass      <= 1'b0;
      done      <= 1'b0;
      pat_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (abort_req && state != IDLE) begin
      state     <= IDLE;
      pass      <= 1'b0;
      done      <= 1'b0;
      pat_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            pass  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          lfsr      <= SEED_V;
          misr      <= '0;
          cnt       <= '0;
          state     <= RUN;
          pat_valid <= 1'b1;
        end
        RUN: begin
          misr <= shift_step(misr) ^ resp_in;
          lfsr <= shift_step(lfsr);
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= CHECK;
            pat_valid <= 1'b0;
          end
        end
        CHECK: begin
          pass  <= (misr == GOLDEN);
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          pat_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Self-checking bench for lfsr_bist_ctrl: vector table of injected response errors,
// pattern scoreboard, plus hand sequences for start-while-busy, held start, reset and abort.
module tb_lfsr_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] pat_out;
  logic       pat_valid;
  logic [2:0] resp_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] signature;
`ifdef BIST_ABORT_EN
  logic       abort = 1'b0;
`endif

  int         checks = 0;
  int         failures = 0;
  int         err_step = 0;
  logic [2:0] err_mask = 3'b000;
  int         pat_idx = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    string      tag;
    int         step;
    logic [2:0] mask;
    logic [2:0] exp_sig;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[5];

  lfsr_bist_ctrl #(
    .WIDTH(3), .TAPS(3'b110), .SEED(3'b100), .NUM_PAT(7), .GOLDEN(3'b110)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pat_out(pat_out),
    .pat_valid(pat_valid),
    .resp_in(resp_in),
    .busy(busy),
    .done(done),
    .pass(pass),
    .signature(signature)
`ifdef BIST_ABORT_EN
    ,
    .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // Loopback UUT with an optional single-bit error injected into one chosen pattern.
  always @(posedge clk) pat_idx <= pat_valid ? pat_idx + 1 : 0;
  always_comb resp_in = pat_out ^ ((pat_valid && (pat_idx + 1 == err_step)) ? err_mask : 3'b000);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference LFSR for TAPS=110: feedback = r[2]^r[1].
  task automatic push_run();
    logic [2:0] r = 3'b100;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(r);
      r = {r[1:0], r[2] ^ r[1]};
    end
  endtask

  task automatic do_start(input bit hold);
    @(negedge clk);
    start = 1'b1;
    push_run();
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic pop_pattern(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_pattern"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pat"}, pat_out, e);
    end
  endtask

  // Entered just after the start edge; follows the run to its done pulse and one cycle beyond.
  task automatic watch_run(input string tag, input logic [2:0] exp_sig, input logic exp_pass,
                           input bit pulse_start);
    int edges = 0;
    int npat = 0;
    bit seen = 0;
    @(negedge clk);
    check({tag, "_pass_clr"}, pass, 0);
    check({tag, "_busy"}, busy, 1);
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (pulse_start) start = (edges == 4 || edges == 8);
      if (pat_valid) begin
        pop_pattern(tag);
        npat++;
      end
      if (done) seen = 1;
    end
    check({tag, "_latency"}, edges, 9);
    check({tag, "_npat"}, npat, 7);
    check({tag, "_sig"}, signature, exp_sig);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_pass_held"}, pass, exp_pass);
    check({tag, "_sig_held"}, signature, exp_sig);
  endtask

  initial begin
    vecs[0] = '{"loopback", 0, 3'b000, 3'b110, 1'b1};
    vecs[1] = '{"p7_b0",    7, 3'b001, 3'b111, 1'b0};
    vecs[2] = '{"p7_b2",    7, 3'b100, 3'b010, 1'b0};
    vecs[3] = '{"p6_b0",    6, 3'b001, 3'b100, 1'b0};
    vecs[4] = '{"p1_b0",    1, 3'b001, 3'b010, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_valid", pat_valid, 0);
    check("rst_pat", pat_out, 3'b100);
    check("rst_sig", signature, 3'b000);

    for (int i = 0; i < 5; i++) begin
      err_step = vecs[i].step;
      err_mask = vecs[i].mask;
      do_start(0);
      watch_run(vecs[i].tag, vecs[i].exp_sig, vecs[i].exp_pass, 0);
    end
    err_step = 0;
    err_mask = 3'b000;
    check("lfsr_held_after_run", pat_out, 3'b100);

    // start pulsed during RUN and CHECK is ignored
    do_start(0);
    watch_run("pulse", 3'b110, 1'b1, 1);
    repeat (3) begin
      @(negedge clk);
      check("pulse_no_restart", busy, 0);
    end

    // start held high: rerun after exactly one IDLE cycle
    err_step = 7;
    err_mask = 3'b001;
    do_start(1);
    watch_run("hold1", 3'b111, 1'b0, 0);
    err_step = 0;
    err_mask = 3'b000;
    push_run();
    @(posedge clk);
    #1;
    start = 1'b0;
    watch_run("hold2", 3'b110, 1'b1, 0);

    // reset on the 4th RUN cycle
    do_start(0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (pat_valid) pop_pattern("rst_mid");
    end
    check("rst_mid_in_run", pat_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", pat_valid, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_pass", pass, 0);
    check("rst_mid_pat", pat_out, 3'b100);
    check("rst_mid_sig", signature, 3'b000);
    rst = 1'b0;
    exp_q.delete();
    do_start(0);
    watch_run("after_rst", 3'b110, 1'b1, 0);

`ifdef BIST_ABORT_EN
    do_start(0);
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (pat_valid) pop_pattern("abort");
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_pass", pass, 0);
    check("abort_done", done, 0);
    check("abort_valid", pat_valid, 0);
    exp_q.delete();
    begin
      bit any_done = 0;
      repeat (12) begin
        @(negedge clk);
        if (done || busy) any_done = 1;
      end
      check("abort_no_done", any_done, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
